// File: rtl/vx_smem_bank_scheduler.sv
// rtl/vx_smem_bank_scheduler.sv - splits a multi-lane shared-memory batch into bank-conflict-free issue slots
// Optional SMEM_PERF_EN adds conflict_count, a count of extra slots caused by bank conflicts.
module vx_smem_bank_scheduler #(
  parameter int NUM_REQS   = 4,
  parameter int NUM_BANKS  = 4,
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8,
  localparam int BANK_SELW = $clog2(NUM_BANKS),
  localparam int LANE_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int BANK_AW   = ADDR_WIDTH - BANK_SELW,
  localparam int BE_W      = DATA_WIDTH / 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_valid,
  input  logic [NUM_REQS-1:0]             req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQS*BE_W-1:0]        req_byteen,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]  req_data,
  input  logic [TAG_WIDTH-1:0]            req_tag,
  output logic                            req_ready,
  output logic [NUM_BANKS-1:0]            bank_valid,
  output logic [NUM_BANKS-1:0]            bank_rw,
  output logic [NUM_BANKS*BANK_AW-1:0]    bank_addr,
  output logic [NUM_BANKS*BE_W-1:0]       bank_byteen,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] bank_data,
  output logic [NUM_BANKS*LANE_W-1:0]     bank_lane,
  output logic [TAG_WIDTH-1:0]            bank_tag,
  output logic                            bank_last,
  input  logic                            bank_ready
`ifdef SMEM_PERF_EN
  , output logic [31:0]                   conflict_count
`endif
);

  logic                           busy;
  logic [NUM_REQS-1:0]            pending;
  logic [NUM_REQS-1:0]            batch_rw;
  logic [NUM_REQS*ADDR_WIDTH-1:0] batch_addr;
  logic [NUM_REQS*BE_W-1:0]       batch_byteen;
  logic [NUM_REQS*DATA_WIDTH-1:0] batch_data;
  logic [TAG_WIDTH-1:0]           batch_tag;
  logic [NUM_REQS-1:0]            issued_mask;
  logic                           fire;
  logic                           accept;

  // Each bank takes its lowest-index pending lane; the rest wait for later slots.
  always_comb begin
    issued_mask = '0;
    bank_valid  = '0;
    bank_rw     = '0;
    bank_addr   = '0;
    bank_byteen = '0;
    bank_data   = '0;
    bank_lane   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (busy && pending[i] && !bank_valid[b] &&
            batch_addr[i*ADDR_WIDTH +: BANK_SELW] == BANK_SELW'(b)) begin
          bank_valid[b]                        = 1'b1;
          issued_mask[i]                       = 1'b1;
          bank_rw[b]                           = batch_rw[i];
          bank_addr[b*BANK_AW +: BANK_AW]      = batch_addr[i*ADDR_WIDTH+BANK_SELW +: BANK_AW];
          bank_byteen[b*BE_W +: BE_W]          = batch_byteen[i*BE_W +: BE_W];
          bank_data[b*DATA_WIDTH +: DATA_WIDTH] = batch_data[i*DATA_WIDTH +: DATA_WIDTH];
          bank_lane[b*LANE_W +: LANE_W]        = LANE_W'(i);
        end
      end
    end
  end

  assign bank_tag  = batch_tag;
  assign bank_last = busy && ((pending & ~issued_mask) == '0);
  assign fire      = (|bank_valid) && bank_ready;
  assign req_ready = !busy || (fire && bank_last);
  assign accept    = (|req_valid) && req_ready;

  // A new batch may load in the same cycle the previous one retires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy         <= 1'b0;
      pending      <= '0;
      batch_rw     <= '0;
      batch_addr   <= '0;
      batch_byteen <= '0;
      batch_data   <= '0;
      batch_tag    <= '0;
    end else if (accept) begin
      busy         <= 1'b1;
      pending      <= req_valid;
      batch_rw     <= req_rw;
      batch_addr   <= req_addr;
      batch_byteen <= req_byteen;
      batch_data   <= req_data;
      batch_tag    <= req_tag;
    end else if (fire) begin
      pending <= pending & ~issued_mask;
      if (bank_last) begin
        busy <= 1'b0;
      end
    end
  end

`ifdef SMEM_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_count <= '0;
    end else if (fire && !bank_last) begin
      conflict_count <= conflict_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_smem_bank_scheduler.sv
// tb/tb_vx_smem_bank_scheduler.sv - self-checking bench for vx_smem_bank_scheduler
// Reference model: per-bank FIFOs of lanes; slot k issues the k-th entry of each FIFO.
module tb_vx_smem_bank_scheduler;
  localparam int NR  = 4;
  localparam int NB  = 4;
  localparam int AW  = 30;
  localparam int DW  = 32;
  localparam int TW  = 8;
  localparam int BS  = 2;
  localparam int IAW = AW - BS;
  localparam int LW  = 2;
  localparam int BW  = DW / 8;
  localparam int SNAP_W = NB*(2+IAW+BW+DW+LW) + TW + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_rw;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*BW-1:0]  req_byteen;
  logic [NR*DW-1:0]  req_data;
  logic [TW-1:0]     req_tag;
  logic              req_ready;
  logic [NB-1:0]     bank_valid;
  logic [NB-1:0]     bank_rw;
  logic [NB*IAW-1:0] bank_addr;
  logic [NB*BW-1:0]  bank_byteen;
  logic [NB*DW-1:0]  bank_data;
  logic [NB*LW-1:0]  bank_lane;
  logic [TW-1:0]     bank_tag;
  logic              bank_last;
  logic              bank_ready;
`ifdef SMEM_PERF_EN
  logic [31:0]       conflict_count;
`endif

  always #5 clk = ~clk;

  vx_smem_bank_scheduler dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_byteen(req_byteen), .req_data(req_data), .req_tag(req_tag),
    .req_ready(req_ready),
    .bank_valid(bank_valid), .bank_rw(bank_rw), .bank_addr(bank_addr),
    .bank_byteen(bank_byteen), .bank_data(bank_data), .bank_lane(bank_lane),
    .bank_tag(bank_tag), .bank_last(bank_last), .bank_ready(bank_ready)
`ifdef SMEM_PERF_EN
    , .conflict_count(conflict_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] perf_exp = '0;

  logic [NR-1:0] b_valid;
  logic [NR-1:0] b_rw;
  logic [AW-1:0] b_addr [NR];
  logic [BW-1:0] b_be   [NR];
  logic [DW-1:0] b_data [NR];
  logic [TW-1:0] b_tag;

  int q_len  [NB];
  int q_lane [NB][NR];
  int n_slots;

  logic [NB-1:0] e_valid;
  int            e_lane [NB];
  logic          e_last;

  function automatic void model();
    n_slots = 0;
    for (int b = 0; b < NB; b++) q_len[b] = 0;
    for (int i = 0; i < NR; i++) begin
      if (b_valid[i]) begin
        int bk;
        bk = int'(b_addr[i] % NB);
        q_lane[bk][q_len[bk]] = i;
        q_len[bk]++;
      end
    end
    for (int b = 0; b < NB; b++) if (q_len[b] > n_slots) n_slots = q_len[b];
  endfunction

  function automatic void expect_slot(input int k);
    for (int b = 0; b < NB; b++) begin
      e_valid[b] = (q_len[b] > k);
      e_lane[b]  = e_valid[b] ? q_lane[b][k] : 0;
    end
    e_last = (k == n_slots - 1);
  endfunction

  task automatic drive_batch();
    req_valid = b_valid;
    req_rw    = b_rw;
    req_tag   = b_tag;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]   = b_addr[i];
      req_byteen[i*BW +: BW] = b_be[i];
      req_data[i*DW +: DW]   = b_data[i];
    end
  endtask

  task automatic fill_payload();
    b_rw  = NR'($urandom);
    b_tag = TW'($urandom);
    for (int i = 0; i < NR; i++) begin
      b_be[i]   = BW'($urandom);
      b_data[i] = $urandom;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bank_valid !== '0 || bank_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: bank_valid=%b bank_last=%b, expected 0 and 0", bank_valid, bank_last);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || bank_valid !== '0) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b bank_valid=%b, expected 1 and 0", req_ready, bank_valid);
    end
`ifdef SMEM_PERF_EN
    checks++;
    if (conflict_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_counter: conflict_count=%0d, expected 0", conflict_count);
    end
`endif
  endtask

  task automatic test_directed();
    logic [AW-1:0] tbl_addr [3][NR];
    logic [NR-1:0] tbl_mask [3];
    tbl_mask[0] = 4'b1111; tbl_addr[0] = '{30'd0, 30'd1, 30'd2, 30'd3};
    tbl_mask[1] = 4'b1111; tbl_addr[1] = '{30'd0, 30'd4, 30'd8, 30'd12};
    tbl_mask[2] = 4'b1010; tbl_addr[2] = '{30'd0, 30'd5, 30'd0, 30'd9};
    for (int c = 0; c < 3; c++) begin
      fill_payload();
      b_valid = tbl_mask[c];
      for (int i = 0; i < NR; i++) b_addr[i] = tbl_addr[c][i];
      model();
      @(negedge clk);
      drive_batch();
      bank_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_accept: req_ready=%b, expected 1", c, req_ready);
      end
      @(posedge clk);
      for (int k = 0; k < n_slots; k++) begin
        @(negedge clk);
        req_valid = '0;
        #1;
        expect_slot(k);
        checks++;
        if (bank_valid !== e_valid || bank_last !== e_last) begin
          errors++;
          $display("FAIL dir%0d_slot%0d: bank_valid=%b bank_last=%b, expected %b %b", c, k, bank_valid, bank_last, e_valid, e_last);
        end
        for (int b = 0; b < NB; b++) begin
          if (e_valid[b]) begin
            checks++;
            if (bank_lane[b*LW +: LW] !== LW'(e_lane[b]) ||
                bank_addr[b*IAW +: IAW] !== b_addr[e_lane[b]][AW-1:BS]) begin
              errors++;
              $display("FAIL dir%0d_slot%0d_bank%0d: lane=%0d addr=%0d, expected lane=%0d addr=%0d", c, k, b,
                       bank_lane[b*LW +: LW], bank_addr[b*IAW +: IAW], e_lane[b], b_addr[e_lane[b]][AW-1:BS]);
            end
          end
        end
        @(posedge clk);
      end
      perf_exp += 32'(n_slots - 1);
      @(negedge clk);
      #1;
      checks++;
      if (bank_valid !== '0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_retire: bank_valid=%b req_ready=%b, expected 0 and 1", c, bank_valid, req_ready);
      end
`ifdef SMEM_PERF_EN
      checks++;
      if (conflict_count !== perf_exp) begin
        errors++;
        $display("FAIL dir%0d_counter: conflict_count=%0d, expected %0d", c, conflict_count, perf_exp);
      end
`endif
    end
  endtask

  task automatic test_stall();
    logic [SNAP_W-1:0] snap;
    int cnt [NR];
    fill_payload();
    b_valid = 4'b1111;
    for (int i = 0; i < NR; i++) begin
      b_addr[i] = AW'(i * 4);
      cnt[i] = 0;
    end
    model();
    @(negedge clk);
    drive_batch();
    bank_ready = 1'b1;
    @(posedge clk);
    for (int k = 0; k < n_slots; k++) begin
      @(negedge clk);
      req_valid = '0;
      if (k == 1) begin
        bank_ready = 1'b0;
        #1;
        snap = {bank_valid, bank_rw, bank_addr, bank_byteen, bank_data, bank_lane, bank_tag, bank_last};
        for (int s = 0; s < 3; s++) begin
          @(posedge clk);
          @(negedge clk);
          #1;
          checks++;
          if ({bank_valid, bank_rw, bank_addr, bank_byteen, bank_data, bank_lane, bank_tag, bank_last} !== snap ||
              req_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d: bank_valid=%b lane=%h req_ready=%b, expected held %b lane=%h req_ready=0",
                     s, bank_valid, bank_lane, req_ready, snap[SNAP_W-1 -: NB], snap[TW+1 +: NB*LW]);
          end
        end
        bank_ready = 1'b1;
      end
      #1;
      for (int b = 0; b < NB; b++) if (bank_valid[b]) cnt[int'(bank_lane[b*LW +: LW])]++;
      @(posedge clk);
    end
    perf_exp += 32'(n_slots - 1);
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (cnt[i] != 1) begin
        errors++;
        $display("FAIL stall_issue_lane%0d: issued %0d times, expected 1", i, cnt[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_payload();
    b_valid = 4'b0011;
    b_addr[0] = 30'd0; b_addr[1] = 30'd4; b_addr[2] = 30'd0; b_addr[3] = 30'd0;
    model();
    @(negedge clk);
    drive_batch();
    bank_ready = 1'b1;
    @(posedge clk);
    b_valid = 4'b1111;
    b_addr[0] = 30'd1; b_addr[1] = 30'd2; b_addr[2] = 30'd3; b_addr[3] = 30'd5;
    b_tag = 8'h5a;
    for (int k = 0; k < n_slots; k++) begin
      @(negedge clk);
      drive_batch();
      #1;
      expect_slot(k);
      checks++;
      if (bank_valid !== e_valid || bank_last !== e_last || req_ready !== e_last ||
          bank_lane[0 +: LW] !== LW'(e_lane[0])) begin
        errors++;
        $display("FAIL b2b_first_slot%0d: bank_valid=%b last=%b req_ready=%b lane0=%0d, expected %b %b %b %0d",
                 k, bank_valid, bank_last, req_ready, bank_lane[0 +: LW], e_valid, e_last, e_last, e_lane[0]);
      end
      @(posedge clk);
    end
    perf_exp += 32'(n_slots - 1);
    model();
    for (int k = 0; k < n_slots; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      expect_slot(k);
      checks++;
      if (bank_valid !== e_valid || bank_last !== e_last || bank_tag !== 8'h5a) begin
        errors++;
        $display("FAIL b2b_second_slot%0d: bank_valid=%b last=%b tag=%h, expected %b %b 5a",
                 k, bank_valid, bank_last, bank_tag, e_valid, e_last);
      end
      for (int b = 0; b < NB; b++) begin
        if (e_valid[b]) begin
          checks++;
          if (bank_lane[b*LW +: LW] !== LW'(e_lane[b])) begin
            errors++;
            $display("FAIL b2b_second_slot%0d_bank%0d: lane=%0d, expected %0d", k, b, bank_lane[b*LW +: LW], e_lane[b]);
          end
        end
      end
      @(posedge clk);
    end
    perf_exp += 32'(n_slots - 1);
  endtask

  task automatic test_reset_mid();
    fill_payload();
    b_valid = 4'b1111;
    for (int i = 0; i < NR; i++) b_addr[i] = AW'(i * 4 + 16);
    @(negedge clk);
    drive_batch();
    bank_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bank_valid !== '0 || bank_last !== 1'b0) begin
      errors++;
      $display("FAIL midreset_drop: bank_valid=%b bank_last=%b, expected 0 and 0", bank_valid, bank_last);
    end
    @(negedge clk);
    reset = 1'b0;
    perf_exp = '0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: req_ready=%b, expected 1", req_ready);
    end
`ifdef SMEM_PERF_EN
    checks++;
    if (conflict_count !== 32'd0) begin
      errors++;
      $display("FAIL midreset_counter: conflict_count=%0d, expected 0", conflict_count);
    end
`endif
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bank_valid !== '0) begin
        errors++;
        $display("FAIL midreset_stale%0d: bank_valid=%b, expected 0", c, bank_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      fill_payload();
      b_valid = NR'($urandom_range(1, 15));
      for (int i = 0; i < NR; i++) b_addr[i] = AW'($urandom);
      model();
      @(negedge clk);
      drive_batch();
      bank_ready = 1'b1;
      @(posedge clk);
      for (int k = 0; k < n_slots; k++) begin
        for (int s = 0; ; s++) begin
          @(negedge clk);
          req_valid  = '0;
          bank_ready = (s >= 3) || ($urandom_range(0, 3) != 0);
          #1;
          expect_slot(k);
          checks++;
          if (bank_valid !== e_valid || bank_last !== e_last || bank_tag !== b_tag ||
              req_ready !== (bank_ready && e_last)) begin
            errors++;
            $display("FAIL rand%0d_slot%0d: bank_valid=%b last=%b tag=%h req_ready=%b, expected %b %b %h %b",
                     n, k, bank_valid, bank_last, bank_tag, req_ready, e_valid, e_last, b_tag, bank_ready && e_last);
          end
          for (int b = 0; b < NB; b++) begin
            if (e_valid[b]) begin
              int l;
              l = e_lane[b];
              checks++;
              if (bank_lane[b*LW +: LW] !== LW'(l) || bank_addr[b*IAW +: IAW] !== b_addr[l][AW-1:BS] ||
                  bank_rw[b] !== b_rw[l] || bank_byteen[b*BW +: BW] !== b_be[l] ||
                  bank_data[b*DW +: DW] !== b_data[l]) begin
                errors++;
                $display("FAIL rand%0d_slot%0d_bank%0d: lane=%0d addr=%h rw=%b be=%h data=%h, expected lane=%0d addr=%h rw=%b be=%h data=%h",
                         n, k, b, bank_lane[b*LW +: LW], bank_addr[b*IAW +: IAW], bank_rw[b],
                         bank_byteen[b*BW +: BW], bank_data[b*DW +: DW],
                         l, b_addr[l][AW-1:BS], b_rw[l], b_be[l], b_data[l]);
              end
            end
          end
          @(posedge clk);
          if (bank_ready) break;
        end
      end
      perf_exp += 32'(n_slots - 1);
    end
    @(negedge clk);
    #1;
`ifdef SMEM_PERF_EN
    checks++;
    if (conflict_count !== perf_exp) begin
      errors++;
      $display("FAIL rand_counter: conflict_count=%0d, expected %0d", conflict_count, perf_exp);
    end
`endif
    checks++;
    if (bank_valid !== '0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rand_idle: bank_valid=%b req_ready=%b, expected 0 and 1", bank_valid, req_ready);
    end
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_rw     = '0;
    req_addr   = '0;
    req_byteen = '0;
    req_data   = '0;
    req_tag    = '0;
    bank_ready = 1'b0;
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
